// File: rtl/sample_window_packer_if.sv
// Stream bundle for sample_window_packer.
// Sample input side, flush pulse, and packed window output side.
interface sample_window_packer_if #(
  parameter int SAMPLE_NUM   = 8,
  parameter int SAMPLE_WIDTH = 8,
  parameter int COUNT_WIDTH  = $clog2(SAMPLE_NUM) + 1
);
  logic                             in_vld;
  logic                             in_rdy;
  logic [SAMPLE_WIDTH-1:0]          in_dat;
  logic                             flush;
  logic                             out_vld;
  logic                             out_rdy;
  logic [SAMPLE_NUM*SAMPLE_WIDTH-1:0] out_dat;
  logic [COUNT_WIDTH-1:0]           out_cnt;

  modport master (
    output in_vld, in_dat, flush, out_rdy,
    input  in_rdy, out_vld, out_dat, out_cnt
  );

  modport slave (
    input  in_vld, in_dat, flush, out_rdy,
    output in_rdy, out_vld, out_dat, out_cnt
  );
endinterface

// File: rtl/sample_window_packer.sv
// Packs SAMPLE_NUM consecutive samples into one word for the adder tree.
// Flush closes a partial window, zero-padding the unused lanes.
module sample_window_packer #(
  parameter int SAMPLE_NUM   = 8,
  parameter int SAMPLE_WIDTH = 8,
  parameter int COUNT_WIDTH  = $clog2(SAMPLE_NUM) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sample_window_packer_if.slave bus
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int CW = COUNT_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_NUM - 1);

  logic [CW-1:0]              cnt;
  logic                       flush_pend;
  logic [SW-1:0]              lanes [SAMPLE_NUM];
  logic [SAMPLE_NUM*SW-1:0]   merged;
  logic                       out_vld_q;
  logic [SAMPLE_NUM*SW-1:0]   out_dat_q;
  logic [CW-1:0]              out_cnt_q;

  logic can_xfer;
  logic in_rdy;
  logic acc;
  logic full;
  logic svc;
  logic part;
  logic load;

  assign can_xfer = !out_vld_q | bus.out_rdy;
  assign in_rdy   = rst_n & !flush_pend
                  & ((cnt < LAST) | can_xfer);
  assign acc      = bus.in_vld & in_rdy;
  assign full     = acc & (cnt == LAST);
  assign svc      = flush_pend & can_xfer;
  assign part     = svc & (cnt != '0);
  assign load     = full | part;

  // Window image: stored lanes below cnt, the incoming sample at cnt, zeros above.
  always_comb begin
    merged = '0;
    for (int i = 0; i < SAMPLE_NUM; i++) begin
      if (acc && cnt == CW'(i))
        merged[i*SW +: SW] = bus.in_dat;
      else if (CW'(i) < cnt)
        merged[i*SW +: SW] = lanes[i];
    end
  end

  // Assembly buffer: write the accepted sample into lane cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SAMPLE_NUM; i++)
        lanes[i] <= '0;
    end else begin
      for (int i = 0; i < SAMPLE_NUM; i++)
        if (acc && cnt == CW'(i))
          lanes[i] <= bus.in_dat;
    end
  end

  // Fill count and pending flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (load)
        cnt <= '0;
      else if (acc)
        cnt <= cnt + 1'b1;
      if (bus.flush)
        flush_pend <= 1'b1;
      else if (svc)
        flush_pend <= 1'b0;
    end
  end

  // Output register: load on a transfer, otherwise drop valid when taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_cnt_q <= '0;
    end else if (load) begin
      out_vld_q <= 1'b1;
      out_dat_q <= merged;
      out_cnt_q <= acc ? cnt + 1'b1 : cnt;
    end else if (bus.out_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  assign bus.in_rdy  = in_rdy;
  assign bus.out_vld = out_vld_q;
  assign bus.out_dat = out_dat_q;
  assign bus.out_cnt = out_cnt_q;

endmodule

// File: tb/tb_sample_window_packer.sv
// Bench for sample_window_packer: directed scenarios plus random traffic
// against a window-list reference model.
module tb_sample_window_packer;

  localparam int N = 8;
  localparam int W = 8;

  typedef struct {
    logic [N*W-1:0] dat;
    logic [3:0]     cnt;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;

  logic [W-1:0] cur [$];
  word_t        exp_q [$];
  word_t        got_q [$];

  sample_window_packer_if #(.SAMPLE_NUM(N), .SAMPLE_WIDTH(W)) bus ();

  sample_window_packer #(.SAMPLE_NUM(N), .SAMPLE_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a window is the list of accepted samples, closed
  // when it reaches N entries or when flush is seen (after that cycle's sample).
  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete();
    end else begin
      word_t w;
      if (bus.in_vld && bus.in_rdy) begin
        cur.push_back(bus.in_dat);
        if (cur.size() == N) begin
          w.dat = '0;
          foreach (cur[k]) w.dat[k*W +: W] = cur[k];
          w.cnt = 4'(cur.size());
          exp_q.push_back(w);
          cur.delete();
        end
      end
      if (bus.flush && cur.size() > 0) begin
        w.dat = '0;
        foreach (cur[k]) w.dat[k*W +: W] = cur[k];
        w.cnt = 4'(cur.size());
        exp_q.push_back(w);
        cur.delete();
      end
      if (bus.out_vld && bus.out_rdy) begin
        w.dat = bus.out_dat;
        w.cnt = bus.out_cnt;
        got_q.push_back(w);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_vld = 0; bus.in_dat = '0;
    bus.flush = 0; bus.out_rdy = 1;
    step(); step();
    checks++;
    if (bus.out_vld !== 1'b0)
      $display("FAIL reset_out_vld got %b want 0", bus.out_vld);
    else passes++;
    checks++;
    if (bus.out_dat !== '0)
      $display("FAIL reset_out_dat got %h want 0", bus.out_dat);
    else passes++;
    checks++;
    if (bus.out_cnt !== '0)
      $display("FAIL reset_out_cnt got %0d want 0", bus.out_cnt);
    else passes++;
    checks++;
    if (bus.in_rdy !== 1'b0)
      $display("FAIL reset_in_rdy got %b want 0", bus.in_rdy);
    else passes++;
    rst_n = 1;
    step();
  endtask

  task automatic test_stream();
    bit ok = 1;
    exp_q.delete(); got_q.delete();
    bus.out_rdy = 1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_vld = 1; bus.in_dat = W'(i);
      #1;
      if (bus.in_rdy !== 1'b1) ok = 0;
      step();
      if (i == 7) begin
        checks++;
        if (bus.out_vld !== 1'b0)
          $display("FAIL stream_early_vld got %b want 0", bus.out_vld);
        else passes++;
      end
      if (i == 8) begin
        checks++;
        if (!(bus.out_vld === 1'b1 && bus.out_dat === 64'h0807060504030201
              && bus.out_cnt === 4'd8))
          $display("FAIL stream_word1 got vld=%b %h cnt=%0d want 1 0807060504030201 8",
                   bus.out_vld, bus.out_dat, bus.out_cnt);
        else passes++;
      end
      if (i == 16) begin
        checks++;
        if (!(bus.out_vld === 1'b1 && bus.out_dat === 64'h100F0E0D0C0B0A09
              && bus.out_cnt === 4'd8))
          $display("FAIL stream_word2 got vld=%b %h cnt=%0d want 1 100f0e0d0c0b0a09 8",
                   bus.out_vld, bus.out_dat, bus.out_cnt);
        else passes++;
      end
    end
    bus.in_vld = 0;
    step();
    checks++;
    if (ok !== 1'b1) $display("FAIL stream_in_rdy got low want always high");
    else passes++;
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 2)
      $display("FAIL stream_words got %0d model %0d want 2", got_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    exp_q.delete(); got_q.delete();
    bus.out_rdy = 1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_vld = 1; bus.in_dat = W'(i);
      step();
    end
    bus.out_rdy = 0;
    for (int i = 0; i < 7; i++) begin
      bus.in_dat = W'(8'h11 + i);
      #1;
      if (bus.in_rdy === 1'b1) accepted++;
      step();
    end
    checks++;
    if (accepted != 7) $display("FAIL bp_accepted got %0d want 7", accepted);
    else passes++;
    bus.in_dat = 8'h18;
    #1;
    checks++;
    if (bus.in_rdy !== 1'b0) $display("FAIL bp_stall_rdy got %b want 0", bus.in_rdy);
    else passes++;
    step();
    checks++;
    if (bus.out_dat !== 64'h0807060504030201 || bus.out_vld !== 1'b1)
      $display("FAIL bp_hold got vld=%b %h want 1 0807060504030201",
               bus.out_vld, bus.out_dat);
    else passes++;
    bus.out_rdy = 1;
    #1;
    checks++;
    if (bus.in_rdy !== 1'b1) $display("FAIL bp_release_rdy got %b want 1", bus.in_rdy);
    else passes++;
    step();
    checks++;
    if (!(bus.out_vld === 1'b1 && bus.out_dat === 64'h1817161514131211
          && bus.out_cnt === 4'd8))
      $display("FAIL bp_word2 got vld=%b %h cnt=%0d want 1 1817161514131211 8",
               bus.out_vld, bus.out_dat, bus.out_cnt);
    else passes++;
    bus.in_vld = 0;
    step();
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 2)
      $display("FAIL bp_words got %0d model %0d want 2", got_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k].dat !== exp_q[k].dat || got_q[k].cnt !== exp_q[k].cnt)
        $display("FAIL bp_model[%0d] got %h/%0d want %h/%0d", k,
                 got_q[k].dat, got_q[k].cnt, exp_q[k].dat, exp_q[k].cnt);
      else passes++;
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] s [3];
    exp_q.delete(); got_q.delete();
    s[0] = 8'hA1; s[1] = 8'hA2; s[2] = 8'hA3;
    bus.out_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_vld = 1; bus.in_dat = s[i];
      step();
    end
    bus.in_vld = 0; bus.flush = 1;
    step();
    bus.flush = 0;
    checks++;
    if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b0)
      $display("FAIL flush_pend got vld=%b rdy=%b want 0 0", bus.out_vld, bus.in_rdy);
    else passes++;
    step();
    checks++;
    if (!(bus.out_vld === 1'b1 && bus.out_dat === 64'h0000000000A3A2A1
          && bus.out_cnt === 4'd3))
      $display("FAIL flush_word got vld=%b %h cnt=%0d want 1 a3a2a1 3",
               bus.out_vld, bus.out_dat, bus.out_cnt);
    else passes++;
    bus.in_vld = 1; bus.in_dat = 8'hB1;
    step();
    bus.in_vld = 0; bus.flush = 1;
    step();
    bus.flush = 0;
    step();
    checks++;
    if (!(bus.out_vld === 1'b1 && bus.out_dat === 64'h00000000000000B1
          && bus.out_cnt === 4'd1))
      $display("FAIL flush_lane0 got vld=%b %h cnt=%0d want 1 b1 1",
               bus.out_vld, bus.out_dat, bus.out_cnt);
    else passes++;
    step();
  endtask

  task automatic test_flush_full();
    exp_q.delete(); got_q.delete();
    bus.out_rdy = 1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_vld = 1; bus.in_dat = W'(i);
      bus.flush = (i == 8);
      step();
    end
    bus.in_vld = 0; bus.flush = 0;
    checks++;
    if (!(bus.out_vld === 1'b1 && bus.out_cnt === 4'd8 && bus.in_rdy === 1'b0))
      $display("FAIL ff_full got vld=%b cnt=%0d rdy=%b want 1 8 0",
               bus.out_vld, bus.out_cnt, bus.in_rdy);
    else passes++;
    step();
    checks++;
    if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1)
      $display("FAIL ff_no_empty got vld=%b rdy=%b want 0 1", bus.out_vld, bus.in_rdy);
    else passes++;
    bus.flush = 1;
    step();
    bus.flush = 0;
    checks++;
    if (bus.in_rdy !== 1'b0) $display("FAIL ff_cnt0_rdy got %b want 0", bus.in_rdy);
    else passes++;
    step();
    checks++;
    if (bus.in_rdy !== 1'b1 || bus.out_vld !== 1'b0)
      $display("FAIL ff_cnt0_after got rdy=%b vld=%b want 1 0", bus.in_rdy, bus.out_vld);
    else passes++;
    step();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL ff_words got %0d model %0d want 1", got_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_random();
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 2000; c++) begin
      bus.in_vld  = ($urandom_range(0, 3) != 0);
      bus.in_dat  = W'($urandom);
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      bus.flush   = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.in_vld = 0; bus.flush = 0; bus.out_rdy = 1;
    step(); step();
    bus.flush = 1;
    step();
    bus.flush = 0;
    repeat (5) step();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() == 0)
      $display("FAIL rand_words got %0d want %0d", got_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k].dat !== exp_q[k].dat || got_q[k].cnt !== exp_q[k].cnt)
        $display("FAIL rand_word[%0d] got %h/%0d want %h/%0d", k,
                 got_q[k].dat, got_q[k].cnt, exp_q[k].dat, exp_q[k].cnt);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    bus.out_rdy = 0;
    for (int i = 1; i <= 13; i++) begin
      bus.in_vld = 1; bus.in_dat = W'(8'h30 + i);
      step();
    end
    bus.in_vld = 0;
    checks++;
    if (bus.out_vld !== 1'b1) $display("FAIL rm_stalled got %b want 1", bus.out_vld);
    else passes++;
    #2 rst_n = 0;
    #1;
    checks++;
    if (!(bus.out_vld === 1'b0 && bus.out_dat === '0 && bus.out_cnt === '0
          && bus.in_rdy === 1'b0))
      $display("FAIL rm_async got vld=%b %h cnt=%0d rdy=%b want 0 0 0 0",
               bus.out_vld, bus.out_dat, bus.out_cnt, bus.in_rdy);
    else passes++;
    step(); step();
    rst_n = 1;
    exp_q.delete(); got_q.delete();
    bus.out_rdy = 1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_vld = 1; bus.in_dat = W'(8'h20 + i);
      step();
    end
    bus.in_vld = 0;
    checks++;
    if (!(bus.out_vld === 1'b1 && bus.out_dat === 64'h2827262524232221
          && bus.out_cnt === 4'd8))
      $display("FAIL rm_clean got vld=%b %h cnt=%0d want 1 2827262524232221 8",
               bus.out_vld, bus.out_dat, bus.out_cnt);
    else passes++;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_full();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
